glyph_pipe_renderer: RTL
========================

// Module: glyph_pipe_renderer
// PURPOSE
//  Pipelined, parametrised tile-glyph renderer. Maps a tile value (index) and
//  in-tile pixel coordinates (x,y) to one pixel bit from an external sync glyph ROM.
//  Adds a vertical active band, optional blank-for-zero tile and a frame-counted
//  "flash" (inverted glyph) effect for newly spawned/merged tiles.
//  Sits between the tile-grid scanner and the colour mux in the VGA pixel path.
// PARAMETERS
//  IDX_W          4   tile value (glyph index) width
//  X_W            6   in-tile x width; ROM byte column = x[X_W-1:3]
//  Y_W            6   in-tile y width
//  ROW_W          5   glyph row bits; row = (y - V_START) mod 2**ROW_W
//  V_START        16  first active row (inclusive)
//  V_END          48  active band end (exclusive); V_START < V_END <= 2**Y_W
//  BLANK_ZERO     1   1: index 0 never lights a pixel
//  FLASH_FRAMES   8   flash duration in frames (1..255)
//  FLASH_RATE     2   log2 frames per flash phase toggle
//  ADDR_W = IDX_W+ROW_W+X_W-3 (localparam)
// PORTS
//  clk          in   1       pixel clock
//  rst_n        in   1       sync reset, active low
//  frame_start  in   1       one-cycle pulse at start of each frame
//  flash_start  in   1       one-cycle pulse: start flash effect
//  in_valid     in   1       x/y/index valid this cycle
//  index        in   IDX_W   tile value
//  x            in   X_W     in-tile column
//  y            in   Y_W     in-tile row
//  rom_addr     out  ADDR_W  glyph ROM address {index,row,x[X_W-1:3]}, registered
//  rom_q        in   8       ROM data, valid one cycle after rom_addr
//  out_valid    out  1       pixel valid
//  pixel        out  1       rendered pixel
//  flashing     out  1       flash counter nonzero
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): rom_addr=0, out_valid=0, pixel=0, flashing=0,
//   flash counter=0, all pipeline sidebands cleared; in-flight pixels are dropped.
//  Stage 1 (cycle N, in_valid=1): register rom_addr; sideband s1 = {valid, x[2:0],
//   active, blank}. active = (y>=V_START)&&(y<V_END); blank = BLANK_ZERO&&(index==0).
//   in_valid=0 -> s1.valid=0, rom_addr holds previous value.
//  Stage 2 (cycle N+1): rom_q returned; register out_valid=s1.valid and
//   pixel = s1.valid & s1.active & ~s1.blank & (rom_q[s1.x[2:0]] ^ inv).
//  Latency: in_valid at edge N -> out_valid/pixel at edge N+2; throughput 1/cycle,
//   no backpressure. out_valid=0 -> pixel=0.
//  Bit order: rom_q bit i = pixel with x[2:0]==i (bit 0 leftmost).
//  Flash counter fcnt (8b), phase counter (FLASH_RATE bits):
//   flash_start: fcnt<=FLASH_FRAMES, phase<=0 (restart, even if already flashing).
//   else frame_start & fcnt!=0: phase++; on phase wrap to 0, fcnt--.
//   flash_start and frame_start same cycle: load wins, no decrement.
//   fcnt==0: counters hold; flash effect off.
//  inv = flashing & ~phase[FLASH_RATE-1] (FLASH_RATE=0: inv=flashing); sampled at stage 2.
//  flashing = (fcnt!=0), registered. Inversion applies only inside active band and
//   non-blank tiles (blank/outside band stay 0 while flashing).
//  Row arithmetic is Y_W-bit subtract truncated to ROW_W; no saturation.
// TESTING
//  1 Reset: hold rst_n=0 2 cycles with in_valid=1 -> out_valid=pixel=flashing=0, rom_addr=0.
//  2 Latency/addr: index=5,y=20,x=0x2B, in_valid 1 cycle -> rom_addr={5,4,5} at N+1;
//    rom_q=8'b0000_1000 -> pixel=1 (bit 3) at N+2 only.
//  3 Band/blank: y=15 and y=48 with rom_q=8'hFF -> pixel=0; index=0 -> pixel=0;
//    y=47,index=2 -> pixel=1.
//  4 Streaming: 64 back-to-back in_valid pixels -> 64 consecutive out_valid, order kept.
//  5 Flash: FLASH_FRAMES=2,FLASH_RATE=1; flash_start then 4 frame_start -> flashing
//    high exactly until 4th frame_start; inverted on frames 0 and 2 only.
//  6 Collisions: flash_start with frame_start -> fcnt=FLASH_FRAMES; rst_n=0 mid-flash
//    and mid-stream -> flashing=0, out_valid=0 next cycle, no stale pixel.

Source files
------------

// File: rtl/glyph_pipe_renderer.sv
// Tile-glyph renderer: two-stage pipe from (index, x, y) to one pixel bit read
// from an external glyph ROM, with a vertical active band, blank-for-zero tiles
// and a frame-counted flash (inverted glyph) effect.
module glyph_pipe_renderer #(
  parameter int unsigned IDX_W        = 4,
  parameter int unsigned X_W          = 6,
  parameter int unsigned Y_W          = 6,
  parameter int unsigned ROW_W        = 5,
  parameter int unsigned V_START      = 16,
  parameter int unsigned V_END        = 48,
  parameter int unsigned BLANK_ZERO   = 1,
  parameter int unsigned FLASH_FRAMES = 8,
  parameter int unsigned FLASH_RATE   = 2,
  localparam int unsigned ADDR_W      = IDX_W + ROW_W + X_W - 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_frame_start,
  input  logic              i_flash_start,
  input  logic              i_in_valid,
  input  logic [IDX_W-1:0]  i_index,
  input  logic [X_W-1:0]    i_x,
  input  logic [Y_W-1:0]    i_y,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [7:0]        i_rom_q,
  output logic              o_out_valid,
  output logic              o_pixel,
  output logic              o_flashing
);

  // Phase counter needs at least one bit even when the flash toggles every frame.
  localparam int unsigned PH_W  = (FLASH_RATE == 0) ? 1 : FLASH_RATE;
  localparam int unsigned FC_W  = 8;

  // Sideband carried alongside the ROM lookup.
  typedef struct packed {
    logic       valid;
    logic [2:0] xb;
    logic       active;
    logic       blank;
  } s1_t;

  s1_t               r_s1;
  logic [ADDR_W-1:0] r_rom_addr;
  logic              r_out_valid;
  logic              r_pixel;
  logic [FC_W-1:0]   r_fcnt;
  logic [PH_W-1:0]   r_phase;
  logic              r_flashing;

  logic [ROW_W-1:0]  w_row;
  logic              w_active;
  logic              w_blank;
  logic [FC_W-1:0]   w_fcnt_d;
  logic [PH_W-1:0]   w_phase_d;
  logic [PH_W-1:0]   w_phase_inc;
  logic              w_phase_wrap;
  logic              w_inv;

  // Glyph row is the band-relative row, wrapping modulo the glyph height.
  assign w_row    = ROW_W'(i_y - Y_W'(V_START));
  assign w_active = (32'(i_y) >= V_START) && (32'(i_y) < V_END);
  assign w_blank  = (BLANK_ZERO != 0) && (i_index == '0);

  // Phase stepping and inversion window; with no rate bits every frame wraps.
  generate
    if (FLASH_RATE == 0) begin : g_rate0
      assign w_phase_inc  = '0;
      assign w_phase_wrap = 1'b1;
      assign w_inv        = r_flashing;
    end else begin : g_rate
      assign w_phase_inc  = r_phase + PH_W'(1);
      assign w_phase_wrap = (w_phase_inc == '0);
      assign w_inv        = r_flashing & ~r_phase[PH_W-1];
    end
  endgenerate

  // Next flash counter/phase: a new flash restarts, frames age an active flash.
  always_comb begin
    w_fcnt_d  = r_fcnt;
    w_phase_d = r_phase;
    if (i_flash_start) begin
      w_fcnt_d  = FC_W'(FLASH_FRAMES);
      w_phase_d = '0;
    end else if (i_frame_start && (r_fcnt != '0)) begin
      w_phase_d = w_phase_inc;
      if (w_phase_wrap) begin
        w_fcnt_d = r_fcnt - FC_W'(1);
      end
    end
  end

  // Flash state registers; flashing tracks the counter it is registered with.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fcnt     <= '0;
      r_phase    <= '0;
      r_flashing <= 1'b0;
    end else begin
      r_fcnt     <= w_fcnt_d;
      r_phase    <= w_phase_d;
      r_flashing <= (w_fcnt_d != '0);
    end
  end

  // Stage 1: issue ROM address and capture sideband; address holds when idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rom_addr <= '0;
      r_s1       <= '0;
    end else begin
      r_s1.valid <= i_in_valid;
      if (i_in_valid) begin
        r_rom_addr  <= {i_index, w_row, i_x[X_W-1:3]};
        r_s1.xb     <= i_x[2:0];
        r_s1.active <= w_active;
        r_s1.blank  <= w_blank;
      end
    end
  end

  // Stage 2: pick the pixel bit from ROM data, apply flash, mask band/blank.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_pixel     <= 1'b0;
    end else begin
      r_out_valid <= r_s1.valid;
      r_pixel     <= r_s1.valid & r_s1.active & ~r_s1.blank
                     & (i_rom_q[r_s1.xb] ^ w_inv);
    end
  end

  assign o_rom_addr  = r_rom_addr;
  assign o_out_valid = r_out_valid;
  assign o_pixel     = r_pixel;
  assign o_flashing  = r_flashing;

endmodule
